// File: rtl/fu_defs_pkg.sv
// rtl/fu_defs_pkg.sv - function-unit select codes, command opcodes and sequencer states
package fu_defs;

   localparam logic [3:0] FS_TRA   = 4'b0000;
   localparam logic [3:0] FS_INC   = 4'b0001;
   localparam logic [3:0] FS_ADD   = 4'b0010;
   localparam logic [3:0] FS_ADDC  = 4'b0011;
   localparam logic [3:0] FS_ADDNB = 4'b0100;
   localparam logic [3:0] FS_SUB   = 4'b0101;
   localparam logic [3:0] FS_DEC   = 4'b0110;
   localparam logic [3:0] FS_AND   = 4'b1000;
   localparam logic [3:0] FS_OR    = 4'b1001;
   localparam logic [3:0] FS_XOR   = 4'b1010;
   localparam logic [3:0] FS_NOT   = 4'b1011;
   localparam logic [3:0] FS_TRB   = 4'b1100;
   localparam logic [3:0] FS_SHR   = 4'b1101;
   localparam logic [3:0] FS_SHL   = 4'b1110;
   localparam logic [3:0] FS_BAD   = 4'b1111;

   localparam logic [4:0] OP_MUL   = 5'b10000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXEC,
      ST_MADD,
      ST_MSHL,
      ST_MSHR,
      ST_DONE
   } state_t;

   // Only the adder-path codes with a meaningful carry-out update C.
   function automatic logic fs_sets_carry(input logic [3:0] fs);
      return (fs >= FS_INC) && (fs <= FS_DEC);
   endfunction

   function automatic state_t start_state(input logic [4:0] op);
      if (op == OP_MUL)
         return ST_MADD;
      else if (!op[4] && (op[3:0] != FS_BAD))
         return ST_EXEC;
      else
         return ST_DONE;
   endfunction

endpackage

// File: rtl/fu_sequencer_regfile.sv
// rtl/fu_sequencer_regfile.sv - NREG x 8 register file, one sync write port, three async read ports
module fu_regfile #(
   parameter int NREG = 4,
   parameter int RAW  = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           we,
   input  logic [RAW-1:0] wa,
   input  logic [7:0]     wd,
   input  logic [RAW-1:0] ra,
   input  logic [RAW-1:0] rb,
   input  logic [RAW-1:0] dbg_addr,
   output logic [7:0]     ra_data,
   output logic [7:0]     rb_data,
   output logic [7:0]     dbg_data
);

   logic [7:0] regs [NREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= 8'd0;
      end else if (we) begin
         regs[wa] <= wd;
      end
   end

   assign ra_data  = regs[ra];
   assign rb_data  = regs[rb];
   assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/fu_sequencer.sv
// rtl/fu_sequencer.sv - command sequencer for the external 8-bit function unit
// Single-pass ALU ops plus an 8-step add/shift unsigned multiply; N/Z/C status kept here.
module fu_sequencer
   import fu_defs::*;
#(
   parameter int NREG = 4,
   parameter int RAW  = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [4:0]     cmd_op,
   input  logic [RAW-1:0] cmd_rd,
   input  logic [RAW-1:0] cmd_ra,
   input  logic [RAW-1:0] cmd_rb,
   input  logic           cmd_use_imm,
   input  logic [7:0]     cmd_imm,
   output logic           done,
   output logic           err,
   output logic [2:0]     flags,
   output logic [7:0]     fu_a,
   output logic [7:0]     fu_b,
   output logic [3:0]     fu_fs,
   input  logic [7:0]     fu_g,
   input  logic           fu_c,
   input  logic [RAW-1:0] dbg_addr,
   output logic [7:0]     dbg_data
);

   state_t         state, state_nxt;
   logic [3:0]     fs_q;
   logic [RAW-1:0] rd_q;
   logic [7:0]     a_q;     // A operand; doubles as multiplicand M
   logic [7:0]     b_q;     // B operand; doubles as multiplier Q
   logic [7:0]     p_q;
   logic [2:0]     cnt_q;
   logic           cmul_q;
   logic           err_q;
   logic [2:0]     flags_q;

   logic           accept;
   logic           we;
   logic [7:0]     wd;
   logic [7:0]     ra_data, rb_data;

   fu_regfile #(.NREG(NREG), .RAW(RAW)) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .wa       (rd_q),
      .wd       (wd),
      .ra       (cmd_ra),
      .rb       (cmd_rb),
      .dbg_addr (dbg_addr),
      .ra_data  (ra_data),
      .rb_data  (rb_data),
      .dbg_data (dbg_data)
   );

   assign accept = cmd_valid && cmd_ready;
   assign flags  = flags_q;

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      fu_a      = 8'd0;
      fu_b      = 8'd0;
      fu_fs     = FS_TRA;
      we        = 1'b0;
      wd        = fu_g;
      case (state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (accept)
               state_nxt = start_state(cmd_op);
         end
         ST_EXEC: begin
            fu_a      = a_q;
            fu_b      = b_q;
            fu_fs     = fs_q;
            we        = 1'b1;
            state_nxt = ST_DONE;
         end
         ST_MADD: begin
            fu_a      = p_q;
            fu_b      = a_q;
            fu_fs     = b_q[0] ? FS_ADD : FS_TRA;
            state_nxt = ST_MSHL;
         end
         ST_MSHL: begin
            fu_b      = a_q;
            fu_fs     = FS_SHL;
            state_nxt = ST_MSHR;
         end
         ST_MSHR: begin
            fu_b  = b_q;
            fu_fs = FS_SHR;
            if (cnt_q == 3'd7) begin
               we        = 1'b1;
               wd        = p_q;
               state_nxt = ST_DONE;
            end else begin
               state_nxt = ST_MADD;
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            err       = err_q;
            cmd_ready = 1'b1;
            state_nxt = accept ? start_state(cmd_op) : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         fs_q    <= FS_TRA;
         rd_q    <= '0;
         a_q     <= 8'd0;
         b_q     <= 8'd0;
         p_q     <= 8'd0;
         cnt_q   <= 3'd0;
         cmul_q  <= 1'b0;
         err_q   <= 1'b0;
         flags_q <= 3'b000;
      end else begin
         state <= state_nxt;
         case (state)
            ST_EXEC: flags_q <= {fu_g[7], fu_g == 8'd0, fs_sets_carry(fs_q) & fu_c};
            ST_MADD: begin
               p_q <= fu_g;
               if (b_q[0])
                  cmul_q <= cmul_q | fu_c;
            end
            ST_MSHL: a_q <= fu_g;
            ST_MSHR: begin
               b_q   <= fu_g;
               cnt_q <= cnt_q + 3'd1;
               if (cnt_q == 3'd7)
                  flags_q <= {p_q[7], p_q == 8'd0, cmul_q};
            end
            default: ;
         endcase
         // Accept only occurs in IDLE/DONE, so it never collides with the updates above.
         if (accept) begin
            fs_q   <= cmd_op[3:0];
            rd_q   <= cmd_rd;
            a_q    <= ra_data;
            b_q    <= cmd_use_imm ? cmd_imm : rb_data;
            p_q    <= 8'd0;
            cnt_q  <= 3'd0;
            cmul_q <= 1'b0;
            err_q  <= (start_state(cmd_op) == ST_DONE);
         end
      end
   end

endmodule

// File: tb/tb_fu_sequencer.sv
// tb/tb_fu_sequencer.sv - scoreboard bench for fu_sequencer with a behavioural function unit
module tb_fu_sequencer;

   localparam int NREG = 4;
   localparam int RAW  = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           cmd_valid = 1'b0;
   logic           cmd_ready;
   logic [4:0]     cmd_op = 5'd0;
   logic [RAW-1:0] cmd_rd = '0, cmd_ra = '0, cmd_rb = '0;
   logic           cmd_use_imm = 1'b0;
   logic [7:0]     cmd_imm = 8'd0;
   logic           done, err;
   logic [2:0]     flags;
   logic [7:0]     fu_a, fu_b, fu_g;
   logic [3:0]     fu_fs;
   logic           fu_c;
   logic [RAW-1:0] dbg_addr = '0;
   logic [7:0]     dbg_data;

   fu_sequencer #(.NREG(NREG), .RAW(RAW)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
      .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm), .done(done), .err(err),
      .flags(flags), .fu_a(fu_a), .fu_b(fu_b), .fu_fs(fu_fs), .fu_g(fu_g),
      .fu_c(fu_c), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   // Behavioural function unit: {carry, result}
   function automatic logic [8:0] fu_fn(input logic [3:0] fs, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] a9, b9;
      a9 = {1'b0, a};
      b9 = {1'b0, b};
      case (fs)
         4'd0:  return a9;
         4'd1:  return a9 + 9'd1;
         4'd2:  return a9 + b9;
         4'd3:  return a9 + b9 + 9'd1;
         4'd4:  return a9 + {1'b0, ~b};
         4'd5:  return a9 + {1'b0, ~b} + 9'd1;
         4'd6:  return a9 + 9'h0FF;
         4'd7:  return a9;
         4'd8:  return {1'b0, a & b};
         4'd9:  return {1'b0, a | b};
         4'd10: return {1'b0, a ^ b};
         4'd11: return {1'b0, ~a};
         4'd12: return b9;
         4'd13: return {1'b0, b >> 1};
         4'd14: return {1'b0, b << 1};
         default: return 9'd0;
      endcase
   endfunction

   always_comb {fu_c, fu_g} = fu_fn(fu_fs, fu_a, fu_b);

   typedef struct {
      int                   cyc;
      logic                 err;
      logic [2:0]           flags;
      logic [NREG-1:0][7:0] regs;
   } exp_t;

   exp_t                 sb[$];
   exp_t                 e;
   logic [NREG-1:0][7:0] mreg = '0;
   logic [2:0]           mflags = 3'b000;
   int                   cyc = 0;
   int                   tests = 0;
   int                   fails = 0;
   bit                   mon_en = 0;
   bit                   bad_fs = 0, bad_err = 0, bad_idle = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse retires the oldest expected command.
   always @(negedge clk) begin
      if (mon_en && done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("err", {31'd0, err}, {31'd0, e.err});
            check("flags", {29'd0, flags}, {29'd0, e.flags});
            for (int i = 0; i < NREG; i++) begin
               dbg_addr = i[RAW-1:0];
               #1;
               check($sformatf("reg%0d", i), {24'd0, dbg_data}, {24'd0, e.regs[i]});
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (fu_fs == 4'hF) bad_fs = 1;
         if (err && !done) bad_err = 1;
         if (cmd_ready && !done && ({fu_a, fu_b, fu_fs} != 20'd0)) bad_idle = 1;
      end
   end

   // Issue one command; when track is set the reference model result is queued.
   task automatic issue(input logic [4:0] op, input int rd, input int ra, input int rb,
                        input logic ui, input logic [7:0] imm, input bit track);
      int         w;
      int         lat;
      logic [7:0] a, b, res, p;
      logic [8:0] r;
      logic       c;
      exp_t       x;
      w = 0;
      @(negedge clk);
      cmd_op = op; cmd_rd = rd[RAW-1:0]; cmd_ra = ra[RAW-1:0]; cmd_rb = rb[RAW-1:0];
      cmd_use_imm = ui; cmd_imm = imm; cmd_valid = 1'b1;
      while (!cmd_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!cmd_ready) begin
         check("accept_timeout", 32'd0, 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      if (!track) return;
      a = mreg[ra];
      b = ui ? imm : mreg[rb];
      x.err = 1'b0;
      if (!op[4] && op[3:0] != 4'hF) begin
         r   = fu_fn(op[3:0], a, b);
         res = r[7:0];
         c   = (op[3:0] >= 4'd1 && op[3:0] <= 4'd6) ? r[8] : 1'b0;
         mreg[rd] = res;
         mflags   = {res[7], res == 8'd0, c};
         lat = 1;
      end else if (op == 5'b10000) begin
         // Shift-and-add with 8-bit accumulator; C records any partial-sum overflow.
         p = 8'd0;
         c = 1'b0;
         for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
               r = {1'b0, p} + {1'b0, 8'((a << i))};
               c = c | r[8];
               p = r[7:0];
            end
         end
         mreg[rd] = p;
         mflags   = {p[7], p == 8'd0, c};
         lat = 24;
      end else begin
         x.err = 1'b1;
         lat = 0;
      end
      x.cyc   = cyc + lat;
      x.flags = mflags;
      x.regs  = mreg;
      sb.push_back(x);
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("drain", sb.size(), 0);
      sb.delete();
      @(negedge clk);
   endtask

   task automatic peek(input string name, input int r, input logic [7:0] v);
      dbg_addr = r[RAW-1:0];
      #1;
      check(name, {24'd0, dbg_data}, {24'd0, v});
   endtask

   initial begin
      logic [4:0] op;
      int         sel;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_flags", {29'd0, flags}, 32'd0);
      check("rst_fu", {12'd0, fu_a, fu_b, fu_fs}, 32'd0);
      for (int i = 0; i < NREG; i++) peek("rst_reg", i, 8'h00);
      mon_en = 1;

      issue(5'b01100, 0, 0, 0, 1'b1, 8'h0C, 1);
      issue(5'b00010, 1, 0, 0, 1'b1, 8'hF4, 1);
      drain();
      peek("add_carry_r1", 1, 8'h00);
      check("add_carry_flags", {29'd0, flags}, 32'b011);

      issue(5'b01100, 2, 0, 0, 1'b1, 8'd13, 1);
      issue(5'b01100, 3, 0, 0, 1'b1, 8'd11, 1);
      issue(5'b10000, 2, 2, 3, 1'b0, 8'h00, 1);
      drain();
      peek("mul_13x11", 2, 8'h8F);
      check("mul_13x11_flags", {29'd0, flags}, 32'b100);

      issue(5'b01100, 0, 0, 0, 1'b1, 8'h10, 1);
      issue(5'b10000, 1, 0, 0, 1'b0, 8'h00, 1);
      issue(5'b01111, 3, 0, 1, 1'b0, 8'h00, 1);
      issue(5'b10101, 2, 1, 1, 1'b1, 8'h77, 1);
      drain();
      check("mul_16x16_flags_after_illegal", {29'd0, flags}, 32'b010);

      // Second command waits with valid high and is taken in the first's done cycle.
      issue(5'b01100, 0, 0, 0, 1'b1, 8'h55, 1);
      issue(5'b00001, 1, 0, 0, 1'b0, 8'h00, 1);
      drain();
      peek("b2b_r1", 1, 8'h56);

      issue(5'b10000, 3, 2, 2, 1'b0, 8'h00, 0);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      mreg = '0;
      mflags = 3'b000;
      @(negedge clk);
      check("abort_ready", {31'd0, cmd_ready}, 32'd1);
      check("abort_flags", {29'd0, flags}, 32'd0);
      peek("abort_rd", 3, 8'h00);
      repeat (30) @(negedge clk);

      for (int n = 0; n < 300; n++) begin
         sel = $urandom_range(0, 19);
         if (sel < 16)      op = {1'b0, sel[3:0]};
         else if (sel < 18) op = 5'b10000;
         else               op = {1'b1, 4'($urandom_range(1, 15))};
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         issue(op, $urandom_range(0, NREG-1), $urandom_range(0, NREG-1),
               $urandom_range(0, NREG-1), 1'($urandom_range(0, 1)), 8'($urandom), 1);
      end
      drain();

      check("fs_never_1111", {31'd0, bad_fs}, 32'd0);
      check("err_only_with_done", {31'd0, bad_err}, 32'd0);
      check("idle_fu_outputs", {31'd0, bad_idle}, 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
